matrix_exec_sequencer: RTL and testbench

Execution-engine stage directly upstream of the matrix ALU.
- Accepts one matrix instruction at a time over a valid/ready handshake.
- Fetches the source matrices from main memory and writes them into the ALU's src1/src2 slots.
- Triggers the ALU operation, reads the ALU result back and stores it to main memory.
- Pulses done (or error) when the instruction is finished.

---
 rtl/matrix_exec_sequencer.sv | 171 +++++++++++++++++
 tb/tb_matrix_exec_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_exec_sequencer.sv
// Execution sequencer in front of the matrix ALU: fetches operands from main memory,
// loads the ALU source slots, triggers the operation and stores the result back.
module matrix_exec_sequencer #(
    parameter int         MEM_LAT  = 1,
    parameter logic [3:0] MEM_BASE = 4'h1,
    parameter logic [3:0] ALU_BASE = 4'h2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         instr_valid,
    input  logic [31:0]  instr,
    output logic         instr_ready,
    output logic [15:0]  mem_addr,
    output logic         mem_nRead,
    output logic         mem_nWrite,
    input  logic [255:0] mem_rdata,
    output logic [255:0] mem_wdata,
    output logic [15:0]  alu_addr,
    output logic         alu_nRead,
    output logic         alu_nWrite,
    output logic [255:0] alu_wdata,
    input  logic [255:0] alu_rdata,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD1,
        S_WA1,
        S_RD2,
        S_WA2,
        S_EXEC,
        S_RES,
        S_CAP,
        S_ST,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] OP_TRANSPOSE = 8'd3;
    localparam logic [7:0] OP_SCALEIMM  = 8'd5;
    localparam logic [7:0] OP_LAST      = 8'd5;
    localparam logic [2:0] LAT_LOAD     = 3'(MEM_LAT - 1);

    localparam logic [3:0] SLOT_SRC1 = 4'h0;
    localparam logic [3:0] SLOT_SRC2 = 4'h1;
    localparam logic [3:0] SLOT_RES  = 4'h2;
    localparam logic [3:0] SLOT_EXEC = 4'h3;

    state_t       state;
    state_t       nxt;
    logic [2:0]   cnt;
    logic [31:0]  ir;
    logic [255:0] data_buf;
    logic [31:0]  cur;
    logic [7:0]   opcode;
    logic [7:0]   dest_idx;
    logic [7:0]   src1_idx;
    logic [7:0]   src2_idx;
    logic         rd_last;
    logic         in_read;

    // In IDLE the instruction being accepted is still on the input bus, not yet in ir.
    assign cur      = (state == S_IDLE) ? instr : ir;
    assign opcode   = cur[31:24];
    assign dest_idx = cur[23:16];
    assign src1_idx = cur[15:8];
    assign src2_idx = cur[7:0];
    assign rd_last  = (cnt == 3'd0);
    assign in_read  = (state == S_RD1) || (state == S_RD2);

    assign alu_wdata = data_buf;
    assign mem_wdata = data_buf;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    nxt = (opcode > OP_LAST) ? S_ERR : S_RD1;
                end
            end
            S_RD1:  if (rd_last) nxt = S_WA1;
            S_WA1: begin
                if (opcode == OP_TRANSPOSE) begin
                    nxt = S_EXEC;
                end else if (opcode == OP_SCALEIMM) begin
                    nxt = S_WA2;
                end else begin
                    nxt = S_RD2;
                end
            end
            S_RD2:  if (rd_last) nxt = S_WA2;
            S_WA2:  nxt = S_EXEC;
            S_EXEC: nxt = S_RES;
            S_RES:  nxt = S_CAP;
            S_CAP:  nxt = S_ST;
            S_ST:   nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            S_ERR:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe is a clean flop output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= 3'd0;
            ir          <= 32'd0;
            data_buf    <= 256'd0;
            mem_addr    <= 16'd0;
            alu_addr    <= 16'd0;
            mem_nRead   <= 1'b1;
            mem_nWrite  <= 1'b1;
            alu_nRead   <= 1'b1;
            alu_nWrite  <= 1'b1;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= nxt;
            instr_ready <= (nxt == S_IDLE);
            busy        <= (nxt != S_IDLE);
            done        <= (nxt == S_DONE);
            error       <= (nxt == S_ERR);
            mem_nRead   <= !((nxt == S_RD1) || (nxt == S_RD2));
            mem_nWrite  <= (nxt != S_ST);
            alu_nWrite  <= !((nxt == S_WA1) || (nxt == S_WA2));
            alu_nRead   <= (nxt != S_RES);

            if ((state == S_IDLE) && instr_valid) begin
                ir <= instr;
            end

            if (((nxt == S_RD1) && (state != S_RD1)) || ((nxt == S_RD2) && (state != S_RD2))) begin
                cnt <= LAT_LOAD;
            end else if (in_read && !rd_last) begin
                cnt <= cnt - 3'd1;
            end

            // The immediate takes the place of the second fetched operand for SCALEIMM.
            if (in_read && rd_last) begin
                data_buf <= mem_rdata;
            end else if ((state == S_WA1) && (nxt == S_WA2)) begin
                data_buf <= {248'd0, src2_idx};
            end else if (state == S_CAP) begin
                data_buf <= alu_rdata;
            end

            case (nxt)
                S_RD1:   mem_addr <= {MEM_BASE, 4'h0, src1_idx};
                S_RD2:   mem_addr <= {MEM_BASE, 4'h0, src2_idx};
                S_ST:    mem_addr <= {MEM_BASE, 4'h0, dest_idx};
                default: mem_addr <= mem_addr;
            endcase

            case (nxt)
                S_WA1:   alu_addr <= {ALU_BASE, 4'h0, opcode[3:0], SLOT_SRC1};
                S_WA2:   alu_addr <= {ALU_BASE, 4'h0, opcode[3:0], SLOT_SRC2};
                S_EXEC:  alu_addr <= {ALU_BASE, 4'h0, opcode[3:0], SLOT_EXEC};
                S_RES:   alu_addr <= {ALU_BASE, 4'h0, opcode[3:0], SLOT_RES};
                default: alu_addr <= alu_addr;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_exec_sequencer.sv
// Randomised bench for matrix_exec_sequencer with behavioural memory and matrix ALU models
// and a per-cycle expected bus trace built from the instruction's phase list.
module tb_matrix_exec_sequencer;

    localparam int         L    = 3;
    localparam logic [3:0] MB   = 4'h1;
    localparam logic [3:0] AB   = 4'h2;
    localparam logic [255:0] JUNK = {8{32'hDEADBEEF}};

    localparam int K_NONE = 0;
    localparam int K_MRD  = 1;
    localparam int K_AWR  = 2;
    localparam int K_EXEC = 3;
    localparam int K_ARD  = 4;
    localparam int K_CAP  = 5;
    localparam int K_MWR  = 6;
    localparam int K_DONE = 7;
    localparam int K_ERR  = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         instr_valid;
    logic [31:0]  instr;
    logic         instr_ready;
    logic [15:0]  mem_addr;
    logic         mem_nRead;
    logic         mem_nWrite;
    logic [255:0] mem_rdata;
    logic [255:0] mem_wdata;
    logic [15:0]  alu_addr;
    logic         alu_nRead;
    logic         alu_nWrite;
    logic [255:0] alu_wdata;
    logic [255:0] alu_rdata;
    logic         busy;
    logic         done;
    logic         error;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    matrix_exec_sequencer #(
        .MEM_LAT (L),
        .MEM_BASE(MB),
        .ALU_BASE(AB)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .mem_addr   (mem_addr),
        .mem_nRead  (mem_nRead),
        .mem_nWrite (mem_nWrite),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .alu_addr   (alu_addr),
        .alu_nRead  (alu_nRead),
        .alu_nWrite (alu_nWrite),
        .alu_wdata  (alu_wdata),
        .alu_rdata  (alu_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    function automatic logic [15:0] el(input logic [255:0] m, input int i, input int j);
        return m[16*(4*i+j) +: 16];
    endfunction

    // 4x4 matrices of 16-bit elements, all arithmetic modulo 2^16.
    function automatic logic [255:0] alu_fn(input logic [3:0] op, input logic [255:0] a,
                                            input logic [255:0] b);
        logic [255:0] r;
        logic [15:0]  acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (op)
                    4'd0: begin
                        acc = 16'd0;
                        for (int k = 0; k < 4; k++) acc = acc + el(a, i, k) * el(b, k, j);
                    end
                    4'd1:    acc = el(a, i, j) + el(b, i, j);
                    4'd2:    acc = el(a, i, j) - el(b, i, j);
                    4'd3:    acc = el(a, j, i);
                    4'd4,
                    4'd5:    acc = el(a, i, j) * b[15:0];
                    default: acc = 16'd0;
                endcase
                r[16*(4*i+j) +: 16] = acc;
            end
        end
        return r;
    endfunction

    // Memory: read data is only valid in the L-th consecutive cycle of a read strobe.
    logic [255:0] mem [256];
    int           rd_run;
    int           wr_count = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) rd_run <= 0;
        else       rd_run <= mem_nRead ? 0 : rd_run + 1;
    end

    assign mem_rdata = (!mem_nRead && (rd_run == L - 1)) ? mem[mem_addr[7:0]] : JUNK;

    always @(posedge Clk) begin
        if (!mem_nWrite) wr_count <= wr_count + 1;
    end

    // ALU: result drives while the read strobe is low and is held afterwards.
    logic [255:0] alu_slot0 = '0;
    logic [255:0] alu_slot1 = '0;
    logic [255:0] alu_hold  = '0;

    always @(posedge Clk) begin
        if (!alu_nWrite && (alu_addr[3:0] == 4'h0)) alu_slot0 <= alu_wdata;
        if (!alu_nWrite && (alu_addr[3:0] == 4'h1)) alu_slot1 <= alu_wdata;
        if (!alu_nRead) alu_hold <= alu_fn(alu_addr[7:4], alu_slot0, alu_slot1);
    end

    assign alu_rdata = !alu_nRead ? alu_fn(alu_addr[7:4], alu_slot0, alu_slot1) : alu_hold;

    task automatic check_output(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [7:0] op;
        if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(6, 255));
        else                           op = 8'($urandom_range(0, 5));
        return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    // Issues one instruction and checks every cycle against the phase list it implies.
    task automatic apply_stimulus(input logic [7:0] op, input logic [7:0] dest, input logic [7:0] s1,
                                  input logic [7:0] s2, input bit chain, input logic [31:0] next_ins,
                                  input int abort_at, output logic [255:0] st_obs);
        int           kind [40];
        logic [15:0]  addr [40];
        logic [255:0] data [40];
        int           k;
        int           total;
        int           done_at;
        int           exp_lat;
        bit           legal;
        bit           aborted;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] res;
        logic [7:0]   exp_ctl;
        logic [7:0]   obs_ctl;

        legal = (op <= 8'd5);
        a     = mem[s1];
        b     = (op == 8'd5) ? {248'd0, s2} : mem[s2];
        res   = alu_fn(op[3:0], a, b);
        for (int i = 0; i < 40; i++) begin
            kind[i] = K_NONE;
            addr[i] = 16'd0;
            data[i] = '0;
        end

        k = 1;
        if (!legal) begin
            kind[k] = K_ERR; k++;
        end else begin
            for (int i = 0; i < L; i++) begin
                kind[k] = K_MRD; addr[k] = {MB, 4'h0, s1}; k++;
            end
            kind[k] = K_AWR; addr[k] = {AB, 4'h0, op[3:0], 4'h0}; data[k] = a; k++;
            if (op == 8'd5) begin
                kind[k] = K_AWR; addr[k] = {AB, 4'h0, op[3:0], 4'h1}; data[k] = b; k++;
            end else if (op != 8'd3) begin
                for (int i = 0; i < L; i++) begin
                    kind[k] = K_MRD; addr[k] = {MB, 4'h0, s2}; k++;
                end
                kind[k] = K_AWR; addr[k] = {AB, 4'h0, op[3:0], 4'h1}; data[k] = b; k++;
            end
            kind[k] = K_EXEC; addr[k] = {AB, 4'h0, op[3:0], 4'h3}; k++;
            kind[k] = K_ARD;  addr[k] = {AB, 4'h0, op[3:0], 4'h2}; k++;
            kind[k] = K_CAP;  k++;
            kind[k] = K_MWR;  addr[k] = {MB, 4'h0, dest}; data[k] = res; k++;
            kind[k] = K_DONE; k++;
        end
        total = k - 1;

        instr       = {op, dest, s1, s2};
        instr_valid = 1'b1;
        check_output("ready_before_accept", 256'(instr_ready), 256'(1'b1));
        @(posedge Clk);

        done_at = 0;
        aborted = 1'b0;
        st_obs  = '0;
        for (k = 1; k <= total + 1; k++) begin
            @(negedge Clk);
            exp_ctl = {k > total, k <= total, kind[k] == K_DONE, kind[k] == K_ERR,
                       kind[k] != K_MRD, kind[k] != K_MWR, kind[k] != K_ARD, kind[k] != K_AWR};
            obs_ctl = {instr_ready, busy, done, error, mem_nRead, mem_nWrite, alu_nRead, alu_nWrite};
            check_output($sformatf("ctl op=%0h k=%0d", op, k), 256'(obs_ctl), 256'(exp_ctl));
            if ((done_at == 0) && (done || error)) done_at = k;
            case (kind[k])
                K_MRD: check_output($sformatf("mem_addr k=%0d", k), 256'(mem_addr), 256'(addr[k]));
                K_AWR: begin
                    check_output($sformatf("alu_addr k=%0d", k), 256'(alu_addr), 256'(addr[k]));
                    check_output($sformatf("alu_wdata k=%0d", k), alu_wdata, data[k]);
                end
                K_EXEC, K_ARD:
                    check_output($sformatf("alu_addr k=%0d", k), 256'(alu_addr), 256'(addr[k]));
                K_MWR: begin
                    check_output("st_addr", 256'(mem_addr), 256'(addr[k]));
                    check_output("st_data", mem_wdata, data[k]);
                    st_obs = mem_wdata;
                end
                default: ;
            endcase
            if (k == abort_at) begin
                Reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (k == 1) begin
                instr_valid = 1'($urandom_range(0, 1));
                instr       = $urandom;
            end
            if (k == total) begin
                if (chain) begin
                    instr       = next_ins;
                    instr_valid = 1'b1;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end

        if (!aborted) begin
            if (!legal)             exp_lat = 1;
            else if (op == 8'd3)    exp_lat = L + 6;
            else if (op == 8'd5)    exp_lat = L + 7;
            else                    exp_lat = 2 * L + 7;
            check_output($sformatf("latency op=%0h", op), 256'(done_at), 256'(exp_lat));
            if (legal) mem[dest] = res;
        end
    endtask

    initial begin
        logic [255:0] st;
        logic [255:0] m;
        logic [255:0] t;
        logic [31:0]  cur_i;
        logic [31:0]  nxt_i;
        bit           ch;
        int           wc;

        Reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        for (int i = 0; i < 256; i++) begin
            for (int w = 0; w < 8; w++) mem[i][32*w +: 32] = $urandom;
        end

        @(negedge Clk);
        @(negedge Clk);
        check_output("reset_ctl", 256'({instr_ready, busy, done, error, mem_nRead, mem_nWrite,
                                        alu_nRead, alu_nWrite}), 256'(8'b1000_1111));
        check_output("reset_mem_addr", 256'(mem_addr), 256'(16'h0000));
        check_output("reset_alu_addr", 256'(alu_addr), 256'(16'h0000));
        check_output("reset_wdata", mem_wdata | alu_wdata, 256'd0);
        Reset = 1'b0;
        @(negedge Clk);

        mem[8'h10] = {16{16'h0001}};
        mem[8'h11] = {16{16'h0002}};
        apply_stimulus(8'd1, 8'h20, 8'h10, 8'h11, 1'b0, 32'd0, 0, st);
        check_output("add_result", st, {16{16'h0003}});

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                m[16*(4*i+j) +: 16] = 16'((i == j) ? 1 : 0) + 16'(i);
                t[16*(4*i+j) +: 16] = 16'((i == j) ? 1 : 0) + 16'(j);
            end
        end
        mem[8'h30] = m;
        apply_stimulus(8'd3, 8'h31, 8'h30, 8'h40, 1'b0, 32'd0, 0, st);
        check_output("transpose_result", st, t);

        mem[8'h50] = {16{16'h0002}};
        apply_stimulus(8'd5, 8'h51, 8'h50, 8'h05, 1'b0, 32'd0, 0, st);
        check_output("scaleimm_result", st, {16{16'h000A}});

        apply_stimulus(8'h09, 8'h01, 8'h02, 8'h03, 1'b0, 32'd0, 0, st);
        apply_stimulus(8'd2, 8'hFF, 8'hFE, 8'hFF, 1'b0, 32'd0, 0, st);
        apply_stimulus(8'd4, 8'h00, 8'hFF, 8'h00, 1'b0, 32'd0, 0, st);

        apply_stimulus(8'd0, 8'h60, 8'h61, 8'h62, 1'b1, {8'd0, 8'h63, 8'h64, 8'h65}, 0, st);
        apply_stimulus(8'd0, 8'h63, 8'h64, 8'h65, 1'b0, 32'd0, 0, st);

        // Abort an ADD in the middle of its second memory read.
        wc = wr_count;
        apply_stimulus(8'd1, 8'h70, 8'h71, 8'h72, 1'b0, 32'd0, L + 3, st);
        #1;
        check_output("abort_ctl", 256'({instr_ready, busy, done, error, mem_nRead, mem_nWrite,
                                        alu_nRead, alu_nWrite}), 256'(8'b1000_1111));
        check_output("abort_addr", 256'({mem_addr, alu_addr}), 256'(32'd0));
        check_output("abort_wdata", mem_wdata | alu_wdata, 256'd0);
        repeat (3) @(negedge Clk);
        Reset       = 1'b0;
        instr_valid = 1'b0;
        @(negedge Clk);
        check_output("after_abort_ready", 256'({instr_ready, busy}), 256'(2'b10));
        repeat (20) @(negedge Clk);
        check_output("no_write_after_reset", 256'(wr_count), 256'(wc));

        cur_i = gen_instr();
        for (int n = 0; n < 24; n++) begin
            nxt_i = gen_instr();
            ch    = (n < 23) && ($urandom_range(0, 1) == 1);
            apply_stimulus(cur_i[31:24], cur_i[23:16], cur_i[15:8], cur_i[7:0], ch, nxt_i, 0, st);
            if (!ch) repeat ($urandom_range(0, 2)) @(negedge Clk);
            cur_i = nxt_i;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
